hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control interface: D/E/M/W hazard inputs toward the controller,
// operand selects, stall/flush vectors, error flag and perf counters back.
interface hazard_ctrl_if #(
    parameter int N_STAGES = 5
);
    logic [4:0]          rs1_d, rs2_d;
    logic [4:0]          rs1_e, rs2_e, rd_e;
    logic [4:0]          rd_m, rd_w;
    logic                reg_write_m, reg_write_w;
    logic                mem_read_e;
    logic                mul_start_e;
    logic                mul_busy;
    logic                branch_hit;
    logic [1:0]          r1_e_sel, r2_e_sel;
    logic [N_STAGES-1:0] stalls, flushes;
    logic                mul_timeout_err;
    logic [31:0]         stall_cycles, flush_events;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output reg_write_m, reg_write_w, mem_read_e, mul_start_e, mul_busy, branch_hit,
        input  r1_e_sel, r2_e_sel, stalls, flushes, mul_timeout_err, stall_cycles, flush_events
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  reg_write_m, reg_write_w, mem_read_e, mul_start_e, mul_busy, branch_hit,
        output r1_e_sel, r2_e_sel, stalls, flushes, mul_timeout_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/multiply stalls and flushes.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int N_STAGES    = 5,
    parameter int MUL_TIMEOUT = 40
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam int S_F = 0;
    localparam int S_D = 1;
    localparam int S_E = 2;
    localparam int S_M = 3;
    localparam int CW  = $clog2(MUL_TIMEOUT + 1);

    typedef enum logic {RUN, MUL_WAIT} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       wait_cnt, wait_cnt_n;
    logic [N_STAGES-1:0] stalls_c, flushes_c;
    logic                load_use;
    logic                timeout_hit;
    logic                err_q;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wm, input logic [4:0] rdm,
                                           input logic       ww, input logic [4:0] rdw);
        if (rs != 5'd0 && wm && rdm == rs)      return 2'd1;
        else if (rs != 5'd0 && ww && rdw == rs) return 2'd2;
        else                                    return 2'd0;
    endfunction

    assign hz.r1_e_sel = rst ? 2'd0 : fwd_sel(hz.rs1_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
    assign hz.r2_e_sel = rst ? 2'd0 : fwd_sel(hz.rs2_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);

    assign load_use = hz.mem_read_e && (hz.rd_e != 5'd0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        stalls_c    = '0;
        flushes_c   = '0;
        timeout_hit = 1'b0;
        if (rst) begin
            flushes_c = '1;
        end else begin
            case (state)
                RUN: begin
                    // A taken branch squashes the load's consumer, so no stall is needed.
                    if (hz.branch_hit) begin
                        flushes_c[S_D] = 1'b1;
                        flushes_c[S_E] = 1'b1;
                    end else if (load_use) begin
                        stalls_c[S_F]  = 1'b1;
                        stalls_c[S_D]  = 1'b1;
                        flushes_c[S_E] = 1'b1;
                    end
                    if (hz.mul_start_e && hz.mul_busy) begin
                        state_n    = MUL_WAIT;
                        wait_cnt_n = '0;
                    end
                end
                MUL_WAIT: begin
                    if (!hz.mul_busy) begin
                        state_n = RUN;
                    end else begin
                        stalls_c[S_F]  = 1'b1;
                        stalls_c[S_D]  = 1'b1;
                        stalls_c[S_E]  = 1'b1;
                        flushes_c[S_M] = 1'b1;
                        // Last permitted wait cycle: give up and resume the pipeline.
                        if (wait_cnt == CW'(MUL_TIMEOUT - 1)) begin
                            timeout_hit = 1'b1;
                            state_n     = RUN;
                        end else begin
                            wait_cnt_n = wait_cnt + CW'(1);
                        end
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign hz.stalls          = stalls_c;
    assign hz.flushes         = flushes_c;
    assign hz.mul_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic        branch_flush;

    assign branch_flush = !rst && (state == RUN) && hz.branch_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stalls_c[S_F]) stall_cnt <= stall_cnt + 32'd1;
            if (branch_flush)  flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle RUN vectors plus
// hand-written multiply-wait, timeout, reset-abandon and perf-counter sequences.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hazard_ctrl_if #(.N_STAGES(5)) hz ();

    hazard_ctrl #(.N_STAGES(5), .MUL_TIMEOUT(40)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       wm, ww, mr, bh;
        logic [1:0] s1, s2;
        logic [4:0] st, fl;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input string nm,
                                input logic [4:0] rs1_d, input logic [4:0] rs2_d,
                                input logic [4:0] rs1_e, input logic [4:0] rs2_e,
                                input logic [4:0] rd_e, input logic [4:0] rd_m, input logic [4:0] rd_w,
                                input logic wm, input logic ww, input logic mr, input logic bh,
                                input logic [1:0] s1, input logic [1:0] s2,
                                input logic [4:0] st, input logic [4:0] fl);
        vec_t v;
        v.name = nm;
        v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e;
        v.rd_e = rd_e; v.rd_m = rd_m; v.rd_w = rd_w;
        v.wm = wm; v.ww = ww; v.mr = mr; v.bh = bh;
        v.s1 = s1; v.s2 = s2; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
        hz.rd_e = '0; hz.rd_m = '0; hz.rd_w = '0;
        hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0; hz.mem_read_e = 1'b0;
        hz.mul_start_e = 1'b0; hz.mul_busy = 1'b0; hz.branch_hit = 1'b0;
    endtask

    task automatic set_load_use();
        hz.mem_read_e = 1'b1; hz.rd_e = 5'd7; hz.rs2_d = 5'd7;
    endtask

    initial begin
        //              name           rs1d rs2d rs1e rs2e rde rdm rdw wm ww mr bh s1 s2 stalls    flushes
        vecs[0]  = mk("idle",          0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        vecs[1]  = mk("fwd_m_prio",    0,   0,   5,   0,   0,  5,  5,  1, 1, 0, 0, 1, 0, 5'b00000, 5'b00000);
        vecs[2]  = mk("fwd_x0",        0,   0,   0,   0,   0,  5,  5,  1, 1, 0, 0, 0, 0, 5'b00000, 5'b00000);
        vecs[3]  = mk("fwd_w_only",    0,   0,   0,   6,   0,  6,  6,  0, 1, 0, 0, 0, 2, 5'b00000, 5'b00000);
        vecs[4]  = mk("fwd_mixed",     0,   0,   9,   3,   0,  3,  9,  1, 1, 0, 0, 2, 1, 5'b00000, 5'b00000);
        vecs[5]  = mk("fwd_nowrite",   0,   0,   4,   4,   0,  4,  4,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        vecs[6]  = mk("load_use_rs2",  0,   7,   0,   0,   7,  0,  0,  0, 0, 1, 0, 0, 0, 5'b00011, 5'b00100);
        vecs[7]  = mk("load_use_gone", 0,   7,   0,   0,   7,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        vecs[8]  = mk("load_x0",       0,   0,   0,   0,   0,  0,  0,  0, 0, 1, 0, 0, 0, 5'b00000, 5'b00000);
        vecs[9]  = mk("load_br",       7,   0,   0,   0,   7,  0,  0,  0, 0, 1, 1, 0, 0, 5'b00000, 5'b00110);
        vecs[10] = mk("branch",        0,   0,   0,   0,   0,  0,  0,  0, 0, 0, 1, 0, 0, 5'b00000, 5'b00110);

        clk = 1'b0;
        rst = 1'b1;
        clear_inputs();

        // Reset values, with forwarding inputs active to show the selects are forced
        repeat (2) @(negedge clk);
        hz.rd_m = 5'd5; hz.reg_write_m = 1'b1; hz.rs1_e = 5'd5;
        #1;
        chk("rst_stalls",  32'(hz.stalls),          32'h00);
        chk("rst_flushes", 32'(hz.flushes),         32'h1f);
        chk("rst_r1_sel",  32'(hz.r1_e_sel),        32'd0);
        chk("rst_err",     32'(hz.mul_timeout_err), 32'd0);
        chk("rst_scyc",    hz.stall_cycles,         32'd0);
        chk("rst_fev",     hz.flush_events,         32'd0);

        // Perf counters: two load-use stalls then one branch
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        set_load_use();
        #1 chk("post_rst_stall_f", 32'(hz.stalls[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        hz.branch_hit = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cycles", hz.stall_cycles, 32'd2);
        chk("perf_flush_events", hz.flush_events, 32'd1);
`else
        chk("perf_stall_cycles", hz.stall_cycles, 32'd0);
        chk("perf_flush_events", hz.flush_events, 32'd0);
`endif

        // Single-cycle vectors in RUN
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            clear_inputs();
            hz.rs1_d = vecs[i].rs1_d; hz.rs2_d = vecs[i].rs2_d;
            hz.rs1_e = vecs[i].rs1_e; hz.rs2_e = vecs[i].rs2_e;
            hz.rd_e = vecs[i].rd_e; hz.rd_m = vecs[i].rd_m; hz.rd_w = vecs[i].rd_w;
            hz.reg_write_m = vecs[i].wm; hz.reg_write_w = vecs[i].ww;
            hz.mem_read_e = vecs[i].mr; hz.branch_hit = vecs[i].bh;
            #1;
            chk({vecs[i].name, "_r1"},      32'(hz.r1_e_sel), 32'(vecs[i].s1));
            chk({vecs[i].name, "_r2"},      32'(hz.r2_e_sel), 32'(vecs[i].s2));
            chk({vecs[i].name, "_stalls"},  32'(hz.stalls),   32'(vecs[i].st));
            chk({vecs[i].name, "_flushes"}, 32'(hz.flushes),  32'(vecs[i].fl));
        end

        // Multiply with three busy wait cycles; branch and load-use ignored while waiting
        @(negedge clk);
        clear_inputs();
        hz.mul_start_e = 1'b1; hz.mul_busy = 1'b1;
        #1 chk("mul_entry_stalls", 32'(hz.stalls), 32'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clear_inputs();
            hz.mul_busy = 1'b1; hz.branch_hit = 1'b1;
            set_load_use();
            #1;
            chk("mul_wait_stalls",  32'(hz.stalls),  32'h07);
            chk("mul_wait_flushes", 32'(hz.flushes), 32'h08);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mul_release_stalls",  32'(hz.stalls),  32'h00);
        chk("mul_release_flushes", 32'(hz.flushes), 32'h00);
        @(negedge clk);
        clear_inputs();
        hz.branch_hit = 1'b1;
        #1 chk("run_after_mul", 32'(hz.flushes), 32'h06);

        // Multiply already done at start: no wait
        @(negedge clk);
        clear_inputs();
        hz.mul_start_e = 1'b1;
        #1 chk("mul_nobusy_stalls", 32'(hz.stalls), 32'h00);
        @(negedge clk);
        clear_inputs();
        hz.branch_hit = 1'b1;
        #1 chk("mul_nobusy_run", 32'(hz.flushes), 32'h06);

        // Timeout: busy held forever
        @(negedge clk);
        clear_inputs();
        hz.mul_start_e = 1'b1; hz.mul_busy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            clear_inputs();
            hz.mul_busy = 1'b1;
            #1 chk("tmo_wait_stalls", 32'(hz.stalls), 32'h07);
        end
        chk("tmo_err_not_yet", 32'(hz.mul_timeout_err), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo_err_set",     32'(hz.mul_timeout_err), 32'd1);
        chk("tmo_back_to_run", 32'(hz.stalls),          32'h00);
        @(negedge clk);
        #1 chk("tmo_err_sticky", 32'(hz.mul_timeout_err), 32'd1);

        // Reset while waiting abandons the wait
        @(negedge clk);
        clear_inputs();
        hz.mul_start_e = 1'b1; hz.mul_busy = 1'b1;
        @(negedge clk);
        clear_inputs();
        hz.mul_busy = 1'b1;
        #1 chk("rstw_waiting", 32'(hz.stalls), 32'h07);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_flushes", 32'(hz.flushes), 32'h1f);
        chk("rstw_stalls",  32'(hz.stalls),  32'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_run_stalls",  32'(hz.stalls),          32'h00);
        chk("rstw_run_flushes", 32'(hz.flushes),         32'h00);
        chk("rstw_err_clear",   32'(hz.mul_timeout_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
